// File: rtl/lava_pkg.sv
// Shared fixed-point types and the raster sampler state encoding for the lava/metaball pipeline.
package lava_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic [31:0] fix_t;

    localparam fix_t ONE_FIX = 32'h0001_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        MOVE   = 3'd5
    } sampler_state_t;

endpackage

// File: rtl/field_sampler_if.sv
// Bus between the field sampler (master) and the metaball array (slave):
// pixel coordinate, strobe, per-ball completion flags and contributions, and the move pulse.
interface field_sampler_if #(
    parameter int N_BALLS = 3
);
    import lava_pkg::*;

    logic                   px_stb;
    fix_t                   p_x;
    fix_t                   p_y;
    logic [N_BALLS-1:0]     vld_in;
    logic [32*N_BALLS-1:0]  w_in;
    logic                   mov_en;

    modport master (
        output px_stb, p_x, p_y, mov_en,
        input  vld_in, w_in
    );

    modport slave (
        input  px_stb, p_x, p_y, mov_en,
        output vld_in, w_in
    );

endinterface

// File: rtl/weight_sum.sv
// Combinational saturating sum of N unsigned Q16.16 contributions; any overflow clamps to all-ones.
module weight_sum
    import lava_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [32*N-1:0] w_in,
    output fix_t            sum
);

    // A single-input instance still needs one guard bit to detect nothing, so keep at least 33 bits.
    localparam int SW = ($clog2(N) > 0) ? (32 + $clog2(N)) : 33;

    logic [SW-1:0] acc_s;

    // Wide accumulation followed by clamp to the fix_t range.
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < N; i++) begin
            acc_s = acc_s + SW'(w_in[32*i +: 32]);
        end
        if (acc_s[SW-1:32] != '0) begin
            sum = 32'hFFFF_FFFF;
        end else begin
            sum = acc_s[31:0];
        end
    end

endmodule

// File: rtl/field_sampler.sv
// Raster-scan field sampler: strobes every pixel to the metaball array, sums and thresholds the field,
// writes the framebuffer, then pulses mov_en once per frame. FIELD_SAMPLER_GRADIENT_EN selects soft-edge shading.
module field_sampler
    import lava_pkg::*;
#(
    parameter int   N_BALLS  = 3,
    parameter int   COLS     = 32,
    parameter int   ROWS     = 64,
    parameter fix_t THRESH   = ONE_FIX,
    parameter int   WAIT_MAX = 64,
    localparam int  AW       = $clog2(COLS*ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    field_sampler_if.master        bus,
    output logic                   pix_we,
    output logic [AW-1:0]          pix_addr,
    output logic [7:0]             pix_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err
);

    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    sampler_state_t state_r;
    logic [CW-1:0]  col_r;
    logic [RW-1:0]  row_r;
    logic [WCW-1:0] wait_cnt_r;

    logic           px_stb_r;
    fix_t           p_x_r;
    fix_t           p_y_r;
    logic           mov_en_r;
    logic           pix_we_r;
    logic [AW-1:0]  pix_addr_r;
    logic [7:0]     pix_data_r;
    logic           busy_r;
    logic           frame_done_r;
    logic           timeout_err_r;

    fix_t           sum_s;
    logic [CW-1:0]  col_nxt_s;
    logic [RW-1:0]  row_nxt_s;
    logic           last_col_s;
    logic           last_row_s;
    logic [AW-1:0]  addr_s;
    logic           all_vld_s;
    logic           wait_expired_s;

    weight_sum #(.N(N_BALLS)) u_weight_sum (
        .w_in (bus.w_in),
        .sum  (sum_s)
    );

    // Map a field sum to an 8-bit intensity.
    function automatic logic [7:0] shade(input fix_t s);
`ifdef FIELD_SAMPLER_GRADIENT_EN
        logic [15:0] ramp;
        if (s < (THRESH >> 1)) begin
            shade = 8'h00;
        end else begin
            ramp  = 16'(s[23:16]) * 16'h0040 + 16'h0040;
            shade = (ramp > 16'h00FF) ? 8'hFF : ramp[7:0];
        end
`else
        shade = (s >= THRESH) ? 8'hFF : 8'h00;
`endif
    endfunction

    assign last_col_s     = (col_r == CW'(COLS - 1));
    assign last_row_s     = (row_r == RW'(ROWS - 1));
    assign addr_s         = AW'(row_r) * AW'(COLS) + AW'(col_r);
    assign all_vld_s      = &bus.vld_in;
    assign wait_expired_s = (wait_cnt_r == WCW'(WAIT_MAX - 1));

    // Next raster position after the current pixel is written.
    always_comb begin
        col_nxt_s = col_r + CW'(1);
        row_nxt_s = row_r;
        if (last_col_s) begin
            col_nxt_s = '0;
            row_nxt_s = row_r + RW'(1);
        end else begin
            row_nxt_s = row_r;
        end
    end

    // Raster FSM with all outputs registered; pulse outputs default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            col_r         <= '0;
            row_r         <= '0;
            wait_cnt_r    <= '0;
            px_stb_r      <= 1'b0;
            p_x_r         <= '0;
            p_y_r         <= '0;
            mov_en_r      <= 1'b0;
            pix_we_r      <= 1'b0;
            pix_addr_r    <= '0;
            pix_data_r    <= 8'h00;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            px_stb_r     <= 1'b0;
            pix_we_r     <= 1'b0;
            mov_en_r     <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        state_r  <= STROBE;
                        col_r    <= '0;
                        row_r    <= '0;
                        p_x_r    <= '0;
                        p_y_r    <= '0;
                        px_stb_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                STROBE: begin
                    state_r <= SETTLE;
                end
                // vld_in may still be high from the previous pixel here, so it is not looked at.
                SETTLE: begin
                    state_r    <= WAIT;
                    wait_cnt_r <= '0;
                end
                WAIT: begin
                    if (all_vld_s) begin
                        state_r    <= WRITE;
                        pix_we_r   <= 1'b1;
                        pix_addr_r <= addr_s;
                        pix_data_r <= shade(sum_s);
                    end else if (wait_expired_s) begin
                        state_r       <= WRITE;
                        pix_we_r      <= 1'b1;
                        pix_addr_r    <= addr_s;
                        pix_data_r    <= shade(32'h0000_0000);
                        timeout_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCW'(1);
                    end
                end
                WRITE: begin
                    if (last_col_s && last_row_s) begin
                        state_r      <= MOVE;
                        col_r        <= '0;
                        row_r        <= '0;
                        mov_en_r     <= 1'b1;
                        frame_done_r <= 1'b1;
                    end else begin
                        state_r  <= STROBE;
                        col_r    <= col_nxt_s;
                        row_r    <= row_nxt_s;
                        p_x_r    <= fix_t'(col_nxt_s) << FRAC_BITS;
                        p_y_r    <= fix_t'(row_nxt_s) << FRAC_BITS;
                        px_stb_r <= 1'b1;
                    end
                end
                MOVE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.px_stb  = px_stb_r;
    assign bus.p_x     = p_x_r;
    assign bus.p_y     = p_y_r;
    assign bus.mov_en  = mov_en_r;
    assign pix_we      = pix_we_r;
    assign pix_addr    = pix_addr_r;
    assign pix_data    = pix_data_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_field_sampler.sv
// Self-checking bench for field_sampler on a 4x2 raster with two behavioural metaball stubs (5-cycle latency).
module tb_field_sampler;
    import lava_pkg::*;

    localparam int NB   = 2;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int NPIX = COLS * ROWS;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_data;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    field_sampler_if #(.N_BALLS(NB)) bus ();

    field_sampler #(
        .N_BALLS  (NB),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .THRESH   (32'h0001_0000),
        .WAIT_MAX (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bus         (bus),
        .pix_we      (pix_we),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Metaball stubs. mode 0: vld drops right after the strobe; mode 1: stale vld stays high
    // through the settle cycle; mode 2: ball 1 never completes. vld rises 5 cycles after the strobe.
    int   stub_mode = 0;
    fix_t w0 = 32'h0;
    fix_t w1 = 32'h0;
    int   age [NB] = '{10, 10};

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bus.px_stb) age[b] <= 1;
            else if (age[b] < 10) age[b] <= age[b] + 1;
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bus.vld_in[b] = 1'b0;
            if (stub_mode == 2 && b == 1) bus.vld_in[b] = 1'b0;
            else if (age[b] >= 5) bus.vld_in[b] = 1'b1;
            else if (stub_mode == 1 && age[b] <= 1) bus.vld_in[b] = 1'b1;
            else bus.vld_in[b] = 1'b0;
        end
        bus.w_in = {w1, w0};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: saturating unsigned sum of the two balls, then binary threshold at 1.0.
    function automatic logic [7:0] model(input fix_t a, input fix_t b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'sh0000_0000_FFFF_FFFF) s = 64'sh0000_0000_FFFF_FFFF;
        return (s >= 64'sh0000_0000_0001_0000) ? 8'hFF : 8'h00;
    endfunction

    // Run one frame, checking addresses, coordinates, data, per-pixel latency, busy and mov_en.
    task automatic run_frame(input string tag, input fix_t a, input fix_t b, input int mode,
                             input logic [7:0] exp_data, input logic exp_err, input int exp_lat,
                             input bit glitch);
        int nw = 0, nmov = 0, nstb = 0, stb_at = 0, busy_drop = 0, stray = 0;
        bit done = 0;
        w0 = a; w1 = b; stub_mode = mode;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (bus.px_stb) begin stb_at = c; nstb++; end
            if (busy !== 1'b1) busy_drop++;
            if (pix_we) begin
                chk($sformatf("%s addr[%0d]", tag, nw), 64'(pix_addr), 64'(nw));
                chk($sformatf("%s data[%0d]", tag, nw), 64'(pix_data), 64'(exp_data));
                chk($sformatf("%s lat[%0d]", tag, nw), 64'(c - stb_at), 64'(exp_lat));
                chk($sformatf("%s p_x[%0d]", tag, nw), 64'(bus.p_x), 64'((nw % COLS) * 65536));
                chk($sformatf("%s p_y[%0d]", tag, nw), 64'(bus.p_y), 64'((nw / COLS) * 65536));
                nw++;
            end
            if (bus.mov_en) begin
                nmov++;
                chk($sformatf("%s done_with_mov", tag), 64'(frame_done), 64'(1));
                chk($sformatf("%s mov_after_last", tag), 64'(nw), 64'(NPIX));
                done = 1;
            end
            frame_start = (glitch && c == 20) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        frame_start = 1'b0;
        chk($sformatf("%s frame_completed", tag), 64'(done), 64'(1));
        chk($sformatf("%s writes", tag), 64'(nw), 64'(NPIX));
        chk($sformatf("%s strobes", tag), 64'(nstb), 64'(NPIX));
        chk($sformatf("%s mov_count", tag), 64'(nmov), 64'(1));
        chk($sformatf("%s busy_held", tag), 64'(busy_drop), 64'(0));
        chk($sformatf("%s busy_after", tag), 64'(busy), 64'(0));
        chk($sformatf("%s timeout_err", tag), 64'(timeout_err), 64'(exp_err));
        for (int c = 0; c < 10; c++) begin
            if (pix_we || bus.mov_en || busy || bus.px_stb) stray++;
            @(negedge clk);
        end
        chk($sformatf("%s idle_after", tag), 64'(stray), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " px_stb"},  64'(bus.px_stb), 64'(0));
        chk({tag, " p_x"},     64'(bus.p_x), 64'(0));
        chk({tag, " p_y"},     64'(bus.p_y), 64'(0));
        chk({tag, " mov_en"},  64'(bus.mov_en), 64'(0));
        chk({tag, " pix_we"},  64'(pix_we), 64'(0));
        chk({tag, " addr"},    64'(pix_addr), 64'(0));
        chk({tag, " data"},    64'(pix_data), 64'(0));
        chk({tag, " busy"},    64'(busy), 64'(0));
        chk({tag, " fdone"},   64'(frame_done), 64'(0));
        chk({tag, " tmo"},     64'(timeout_err), 64'(0));
    endtask

    typedef struct {
        fix_t       w0;
        fix_t       w1;
        int         mode;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   found;
        int   stray;
        fix_t ra, rb;
        vecs[0] = '{32'h0000_8000, 32'h0000_8000, 1, 8'hFF, 1'b0, 6};
        vecs[1] = '{32'h0000_4000, 32'h0000_3FFF, 0, 8'h00, 1'b0, 6};
        vecs[2] = '{32'hFFFF_0000, 32'hFFFF_0000, 0, 8'hFF, 1'b0, 6};
        vecs[3] = '{32'h0000_FFFF, 32'h0000_0000, 1, 8'h00, 1'b0, 6};
        vecs[4] = '{32'h0001_0000, 32'h0000_0000, 0, 8'hFF, 1'b0, 6};
        vecs[5] = '{32'h0000_8000, 32'h0000_8000, 2, 8'h00, 1'b1, 66};
        vecs[6] = '{32'h0002_0000, 32'h0000_0001, 1, 8'hFF, 1'b1, 6};

        rst = 1'b1; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].mode,
                      vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0: begin ra = $urandom_range(0, 32'h0000_C000); rb = $urandom_range(0, 32'h0000_C000); end
                1: begin ra = $urandom; rb = $urandom; end
                default: begin
                    ra = $urandom_range(0, 32'h0001_0000);
                    rb = 32'h0001_0000 - ra - fix_t'($urandom_range(0, 1));
                end
            endcase
            run_frame($sformatf("rnd%0d", i), ra, rb, int'($urandom_range(0, 1)),
                      model(ra, rb), 1'b1, 6, 1'b0);
        end

        // Reset while pixel 3 is in flight abandons the frame and clears the sticky error.
        w0 = 32'h0000_8000; w1 = 32'h0000_8000; stub_mode = 0;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        found = 0;
        for (int c = 0; c < 500 && found == 0; c++) begin
            if (bus.px_stb && bus.p_x == 32'h0003_0000) found = 1;
            else @(negedge clk);
        end
        chk("rst pixel3_reached", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 100; c++) begin
            if (pix_we || bus.mov_en || busy || bus.px_stb) stray++;
            @(negedge clk);
        end
        chk("midrst stays_idle", 64'(stray), 64'(0));

        run_frame("post_rst", 32'h0000_8000, 32'h0000_8000, 0, 8'hFF, 1'b0, 6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
